// File: rtl/demux1x2_buf.sv
// demux1x2_buf: 1-to-2 demultiplexer with an independent 2-entry FIFO per
// output channel.
// Optional build macro: DEMUX_CONT_EN adds ports cont0/cont1, which are 16-bit
// accepted-word counters per channel.
// Each FIFO holds its head in mem0 and its second word in mem1.
// ocup is the occupancy of the FIFO: 0 (empty), 1 (one word) or 2 (full).
// There is no bypass path. A full FIFO refuses a push even in a cycle
// where it also pops.
module demux1x2_buf #(
  parameter int LARGURA = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [LARGURA-1:0] entrada,
  input  logic               entrada_valida,
  input  logic               seletor,
  output logic               entrada_pronta,
  output logic [LARGURA-1:0] saida0,
  output logic               saida0_valida,
  input  logic               saida0_pronta,
  output logic [LARGURA-1:0] saida1,
  output logic               saida1_valida,
  input  logic               saida1_pronta
`ifdef DEMUX_CONT_EN
  ,
  output logic [15:0]        cont0,
  output logic [15:0]        cont1
`endif
);

  logic [LARGURA-1:0] mem0 [2];
  logic [LARGURA-1:0] mem1 [2];
  logic [1:0]         ocup [2];
  logic [1:0]         push;
  logic [1:0]         pop;

  // Handshake decode: ready follows the fullness of the selected FIFO only
  always_comb begin
    entrada_pronta = seletor ? (ocup[1] != 2'd2) : (ocup[0] != 2'd2);
    push[0]        = entrada_valida & entrada_pronta & ~seletor;
    push[1]        = entrada_valida & entrada_pronta &  seletor;
    saida0_valida  = (ocup[0] != 2'd0);
    saida1_valida  = (ocup[1] != 2'd0);
    pop[0]         = saida0_valida & saida0_pronta;
    pop[1]         = saida1_valida & saida1_pronta;
    saida0         = saida0_valida ? mem0[0] : '0;
    saida1         = saida1_valida ? mem0[1] : '0;
  end

  // Per-channel FIFO storage and occupancy update
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        mem0[i] <= '0;
        mem1[i] <= '0;
        ocup[i] <= 2'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (ocup[i])
          2'd0: begin
            if (push[i]) begin
              mem0[i] <= entrada;
              ocup[i] <= 2'd1;
            end
          end
          2'd1: begin
            if (push[i] && pop[i]) begin
              mem0[i] <= entrada;
            end else if (push[i]) begin
              mem1[i] <= entrada;
              ocup[i] <= 2'd2;
            end else if (pop[i]) begin
              ocup[i] <= 2'd0;
            end
          end
          2'd2: begin
            if (pop[i]) begin
              mem0[i] <= mem1[i];
              ocup[i] <= 2'd1;
            end
          end
          default: ocup[i] <= 2'd0;
        endcase
      end
    end
  end

`ifdef DEMUX_CONT_EN
  // Accepted-word counters; they wrap naturally at 16 bits
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cont0 <= 16'd0;
      cont1 <= 16'd0;
    end else begin
      if (push[0]) cont0 <= cont0 + 16'd1;
      if (push[1]) cont1 <= cont1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_demux1x2_buf.sv
// tb_demux1x2_buf: scoreboard bench for demux1x2_buf.
// The cont0/cont1 checks are built only when DEMUX_CONT_EN is defined.
module tb_demux1x2_buf;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] entrada;
  logic        entrada_valida;
  logic        seletor;
  logic        entrada_pronta;
  logic [31:0] saida0, saida1;
  logic        saida0_valida, saida1_valida;
  logic        saida0_pronta, saida1_pronta;
`ifdef DEMUX_CONT_EN
  logic [15:0] cont0, cont1;
`endif

  int unsigned erros = 0;
  int unsigned total = 0;

  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [15:0] e0 = 16'd0;
  logic [15:0] e1 = 16'd0;

  demux1x2_buf #(.LARGURA(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .entrada        (entrada),
    .entrada_valida (entrada_valida),
    .seletor        (seletor),
    .entrada_pronta (entrada_pronta),
    .saida0         (saida0),
    .saida0_valida  (saida0_valida),
    .saida0_pronta  (saida0_pronta),
    .saida1         (saida1),
    .saida1_valida  (saida1_valida),
    .saida1_pronta  (saida1_pronta)
`ifdef DEMUX_CONT_EN
    ,
    .cont0          (cont0),
    .cont1          (cont1)
`endif
  );

  always #5 clock = ~clock;

  task automatic verif(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      erros++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, then check the outputs at the falling edge
  // against the scoreboard, and then apply what the rising edge does
  task automatic ciclo(input logic v, input logic sel, input logic [31:0] d,
                       input logic p0, input logic p1);
    logic exp_pronta;
    entrada_valida = v;
    seletor        = sel;
    entrada        = d;
    saida0_pronta  = p0;
    saida1_pronta  = p1;
    @(negedge clock);
    exp_pronta = sel ? (q1.size() != 2) : (q0.size() != 2);
    verif("pronta",  {63'd0, entrada_pronta}, {63'd0, exp_pronta});
    verif("valida0", {63'd0, saida0_valida},  {63'd0, q0.size() != 0});
    verif("valida1", {63'd0, saida1_valida},  {63'd0, q1.size() != 0});
    verif("saida0",  {32'd0, saida0}, {32'd0, (q0.size() != 0) ? q0[0] : 32'd0});
    verif("saida1",  {32'd0, saida1}, {32'd0, (q1.size() != 0) ? q1[0] : 32'd0});
`ifdef DEMUX_CONT_EN
    verif("cont0", {48'd0, cont0}, {48'd0, e0});
    verif("cont1", {48'd0, cont1}, {48'd0, e1});
`endif
    if (p0 && q0.size() != 0) void'(q0.pop_front());
    if (p1 && q1.size() != 0) void'(q1.pop_front());
    if (v && exp_pronta) begin
      if (sel) begin
        q1.push_back(d);
        e1 = e1 + 16'd1;
      end else begin
        q0.push_back(d);
        e0 = e0 + 16'd1;
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n        = 1'b0;
    entrada        = 32'd0;
    entrada_valida = 1'b0;
    seletor        = 1'b0;
    saida0_pronta  = 1'b0;
    saida1_pronta  = 1'b0;
    #3;
    verif("rst_v0", {63'd0, saida0_valida}, 64'd0);
    verif("rst_v1", {63'd0, saida1_valida}, 64'd0);
    verif("rst_s0", {32'd0, saida0}, 64'd0);
    verif("rst_s1", {32'd0, saida1}, 64'd0);
    verif("rst_pronta", {63'd0, entrada_pronta}, 64'd1);
    #9 reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Basic routing to both channels while both consumers stall
    ciclo(1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
    verif("rota_s0", {32'd0, saida0}, 64'h0000_0000_DEAD_BEEF);
    verif("rota_v0", {63'd0, saida0_valida}, 64'd1);
    ciclo(1'b1, 1'b1, 32'h12345678, 1'b0, 1'b0);
    verif("rota_s1", {32'd0, saida1}, 64'h0000_0000_1234_5678);
    verif("rota_v1", {63'd0, saida1_valida}, 64'd1);
    ciclo(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    verif("um_v0", {63'd0, saida0_valida}, 64'd0);
    verif("um_v1", {63'd0, saida1_valida}, 64'd0);

    // Full backpressure on channel 0
    ciclo(1'b1, 1'b0, 32'hAAAA0001, 1'b0, 1'b0);
    ciclo(1'b1, 1'b0, 32'hBBBB0002, 1'b0, 1'b0);
    entrada_valida = 1'b1; seletor = 1'b0; entrada = 32'hCCCC0003;
    #1 verif("cheio_pronta", {63'd0, entrada_pronta}, 64'd0);
    ciclo(1'b1, 1'b0, 32'hCCCC0003, 1'b0, 1'b0);
    seletor = 1'b1;
    #1 verif("cheio_sel1", {63'd0, entrada_pronta}, 64'd1);
    // A full FIFO stays not ready even while it pops in the same cycle
    ciclo(1'b1, 1'b0, 32'hCCCC0004, 1'b1, 1'b0);
    verif("cheio_b", {32'd0, saida0}, 64'h0000_0000_BBBB_0002);
    ciclo(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    verif("dreno_v0", {63'd0, saida0_valida}, 64'd0);

    // Same-channel push and pop at occupancy one
    ciclo(1'b1, 1'b1, 32'h0000_00AA, 1'b0, 1'b0);
    ciclo(1'b1, 1'b1, 32'h0000_00BB, 1'b0, 1'b1);
    verif("pp_s1", {32'd0, saida1}, 64'h0000_0000_0000_00BB);
    verif("pp_v1", {63'd0, saida1_valida}, 64'd1);
    ciclo(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    verif("pp_ocup", {63'd0, saida1_valida}, 64'd0);

    // Random traffic on both channels
    for (int k = 0; k < 400; k++)
      ciclo(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Reset in the middle of operation, with both FIFOs full
    for (int k = 0; k < 4; k++)
      ciclo(1'b1, 1'(k % 2), 32'h5000_0000 + k, 1'b0, 1'b0);
    verif("pre_rst_v0", {63'd0, saida0_valida}, 64'd1);
    entrada_valida = 1'b0; saida0_pronta = 1'b0; saida1_pronta = 1'b0;
    reset_n = 1'b0;
    #1;
    verif("mrst_v0", {63'd0, saida0_valida}, 64'd0);
    verif("mrst_v1", {63'd0, saida1_valida}, 64'd0);
    verif("mrst_s0", {32'd0, saida0}, 64'd0);
    verif("mrst_s1", {32'd0, saida1}, 64'd0);
`ifdef DEMUX_CONT_EN
    verif("mrst_c0", {48'd0, cont0}, 64'd0);
`endif
    #2 reset_n = 1'b1;
    q0.delete(); q1.delete(); e0 = 16'd0; e1 = 16'd0;
    @(posedge clock);
    #1;
    verif("pos_rst_pronta", {63'd0, entrada_pronta}, 64'd1);
    ciclo(1'b1, 1'b0, 32'h7777_0000, 1'b0, 1'b0);
    ciclo(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);

`ifdef DEMUX_CONT_EN
    // Counter wrap on channel 0
    ciclo(1'b1, 1'b1, 32'h1, 1'b1, 1'b1);
    while (e0 != 16'hFFFF) ciclo(1'b1, 1'b0, {16'd0, e0}, 1'b1, 1'b1);
    begin
      logic [15:0] c1_antes;
      c1_antes = e1;
      ciclo(1'b1, 1'b0, 32'hFFFF_0000, 1'b1, 1'b0);
      verif("wrap_c0", {48'd0, cont0}, 64'd0);
      verif("wrap_c1", {48'd0, cont1}, {48'd0, c1_antes});
    end
    ciclo(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", erros, total);
    $finish;
  end

endmodule
